// File: rtl/midi_voice_period_bank.sv
// Polyphonic note-to-half-period bank: a small sequential FSM derives each voice's
// half-period (table lookup, divide-by-12, octave shift) and NUM_VOICES square counters run from it.
module midi_voice_period_bank #(
    parameter int NUM_VOICES = 4,
    parameter int TICK_W     = 24,
    parameter int TRANSPOSE  = 0,
    parameter int VOICE_W    = 2
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         sample_tick,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic [VOICE_W-1:0]           cmd_voice,
    input  logic [6:0]                   cmd_note,
    input  logic                         cmd_gate,
    output logic                         cmd_err,
    output logic [NUM_VOICES-1:0]        voice_active,
    output logic [NUM_VOICES-1:0]        voice_sq,
    output logic [NUM_VOICES*TICK_W-1:0] voice_period
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_DIV   = 2'd1;
    localparam logic [1:0] S_SHIFT = 2'd2;
    localparam logic [1:0] S_WRITE = 2'd3;

    logic [1:0]         state;
    logic [6:0]         rem;
    logic [3:0]         oct;
    logic [VOICE_W-1:0] cap_voice;
    logic               cap_gate;
    logic [TICK_W-1:0]  period_r;
    logic [6:0]         note_eff;
    int                 note_sum;
    logic               voice_ok;

    // Base-octave half-periods for notes 0..11; higher octaves are right shifts of these.
    function automatic logic [14:0] base_half_period(input logic [3:0] idx);
        case (idx)
            4'd0:    return 15'd23889;
            4'd1:    return 15'd22548;
            4'd2:    return 15'd21282;
            4'd3:    return 15'd20088;
            4'd4:    return 15'd18960;
            4'd5:    return 15'd17896;
            4'd6:    return 15'd16892;
            4'd7:    return 15'd15944;
            4'd8:    return 15'd15049;
            4'd9:    return 15'd14204;
            4'd10:   return 15'd13407;
            4'd11:   return 15'd12654;
            default: return 15'd0;
        endcase
    endfunction

    // NOTE: every variable assigned in always_comb gets a value on every path, so no latch is inferred.
    always_comb begin
        note_sum = int'(cmd_note) + TRANSPOSE;
        note_eff = 7'd0;
        if (note_sum > 127)
            note_eff = 7'd127;
        else if (note_sum > 0)
            note_eff = 7'(note_sum);
    end

    assign cmd_ready = (state == S_IDLE);
    assign voice_ok  = (int'(cap_voice) < NUM_VOICES);
    assign cmd_err   = (state == S_WRITE) && !voice_ok;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            rem       <= 7'd0;
            oct       <= 4'd0;
            cap_voice <= '0;
            cap_gate  <= 1'b0;
            period_r  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        cap_voice <= cmd_voice;
                        cap_gate  <= cmd_gate;
                        rem       <= note_eff;
                        oct       <= 4'd0;
                        state     <= cmd_gate ? S_DIV : S_WRITE;
                    end
                end
                S_DIV: begin
                    if (rem >= 7'd12) begin
                        rem <= rem - 7'd12;
                        oct <= oct + 4'd1;
                    end else begin
                        state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    period_r <= TICK_W'(base_half_period(rem[3:0]) >> oct);
                    state    <= S_WRITE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    for (genvar v = 0; v < NUM_VOICES; v++) begin : g_voice
        logic [TICK_W-1:0] period_q;
        logic [TICK_W-1:0] cnt;
        logic              active_q;
        logic              sq_q;
        logic              wr;

        assign wr = (state == S_WRITE) && voice_ok && (cap_voice == VOICE_W'(v));

        // NOTE: per-voice state is a handful of flops that must read 0 after reset, so it is reset explicitly.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                period_q <= '0;
                cnt      <= '0;
                active_q <= 1'b0;
                sq_q     <= 1'b0;
            end else if (wr) begin
                active_q <= cap_gate;
                cnt      <= '0;
                sq_q     <= 1'b0;
                if (cap_gate)
                    period_q <= period_r;
            end else if (!active_q) begin
                cnt  <= '0;
                sq_q <= 1'b0;
            end else if (sample_tick) begin
                if (cnt == period_q - TICK_W'(1)) begin
                    cnt  <= '0;
                    sq_q <= ~sq_q;
                end else begin
                    cnt <= cnt + TICK_W'(1);
                end
            end
        end

        assign voice_period[v*TICK_W +: TICK_W] = period_q;
        assign voice_active[v]                  = active_q;
        assign voice_sq[v]                      = sq_q;
    end

endmodule

// File: doc/midi_voice_period_bank.md
Name: midi_voice_period_bank

Overview:
- Polyphonic successor to the single-note, combinational note-to-ticks lookup.
- Accepts note-on/off commands over a valid/ready handshake and derives each voice's half-period in sample ticks sequentially: a 12-entry base-octave table, a divide-by-12 loop and a right shift by octave. A compile-time transpose is applied before the derivation.
- Runs NUM_VOICES square-wave counters clocked by the sample-rate enable.
- Sits between the MIDI parser and the mixer in the element14 sound module.

Parameters:
- NUM_VOICES, 4: number of independent voices (1..16).
- TICK_W, 24: width of period and counter registers (>=15).
- TRANSPOSE, 0: signed semitone offset added to every note (-24..24).
- VOICE_W, 2: width of cmd_voice; must be >= clog2(NUM_VOICES), minimum 1.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- sample_tick  in  1  one-cycle sample-rate enable pulse
- cmd_valid  in  1  command valid
- cmd_ready  out  1  high only in IDLE
- cmd_voice  in  VOICE_W  target voice index
- cmd_note  in  7  MIDI note number 0..127
- cmd_gate  in  1  1 = note on, 0 = note off
- cmd_err  out  1  one-cycle pulse when a command targets voice >= NUM_VOICES
- voice_active  out  NUM_VOICES  per-voice gate state
- voice_sq  out  NUM_VOICES  per-voice square output
- voice_period  out  NUM_VOICES*TICK_W  per-voice half-period; voice v occupies bits [v*TICK_W +: TICK_W]

Behaviour:
- Reset (async assert, sync release): state=IDLE; cmd_ready=1; cmd_err=0; all voice_active, voice_sq, voice_period and counters = 0.
- Base table, notes 0..11: 23889, 22548, 21282, 20088, 18960, 17896, 16892, 15944, 15049, 14204, 13407, 12654.
- Handshake: a command is accepted on a rising edge with cmd_valid & cmd_ready. Inputs are captured at acceptance; no later sampling.
- Note derivation: note_eff = cmd_note + TRANSPOSE, computed signed and clamped to 0..127.
- FSM states: IDLE, DIV, SHIFT, WRITE.
- IDLE, accept with gate=1: rem=note_eff, oct=0, go to DIV.
- IDLE, accept with gate=0: go directly to WRITE.
- DIV: each cycle, if rem>=12 then rem-=12, oct+=1 and stay; else go to SHIFT. DIV lasts oct+1 cycles; oct max is 10.
- SHIFT: period = table[rem] >> oct, truncating, zero-extended to TICK_W. Go to WRITE.
- WRITE: go to IDLE; cmd_ready is high the following cycle.
- WRITE, voice in range, gate=1: voice_period = period, voice_active=1, counter=0, voice_sq=0.
- WRITE, voice in range, gate=0: voice_active=0, counter=0, voice_sq=0; voice_period is retained.
- WRITE, voice out of range: no voice state changes; cmd_err=1 for exactly this cycle.
- Busy time: gate=1 occupies oct+3 cycles from acceptance to cmd_ready high; gate=0 occupies 1 cycle.
- Voice counter, active voice on sample_tick: if counter == period-1, then counter=0 and voice_sq toggles; else counter+1.
- Inactive voices: counter and voice_sq held at 0.
- Counters run with no sample_tick dependency on FSM state. If the WRITE cycle coincides with sample_tick on the same voice, WRITE wins.
- Other voices keep running undisturbed during any command.
- Retriggering an active voice with a new note restarts its phase at 0.
- Reset asserted mid-command: the command is aborted and all state returns to reset values.

Test Plan:
- Reset, then note 69 gate=1 to voice 0 (TRANSPOSE=0) -> cmd_ready low for 8 cycles; voice_period[0]=443; with sample_tick every cycle, voice_sq[0] toggles every 443 cycles.
- Note 60 to voice 1, then note 127 to voice 2 back-to-back with cmd_valid held -> periods 746 and 15; second acceptance happens exactly 8 cycles after the first; voice 0 phase is unaffected.
- Note 0 (busy 3 cycles) and note 11 -> periods 23889 and 12654.
- TRANSPOSE=12 build, notes 120 and 0 -> 120 clamps to 127 giving 15; 0 becomes 12 giving 11944.
- Note off to voice 0 while active -> voice_active[0]=0, voice_sq[0]=0, period stays 443; cmd_ready drops for 1 cycle.
- NUM_VOICES=3, command to voice 3 -> cmd_err pulses once, no voice changes.
- Assert reset_n low during DIV -> all outputs 0 immediately; cmd_ready=1 after release.
